// File: rtl/mux_rr_pipe_pkg.sv
// ============================================================================
// Module : mux_rr_pipe_pkg
// Brief  : Mode encodings and flattened-bus helper for the pipelined selector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_rr_pipe_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Low bit of channel idx within a bus of width-bit lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_pipe_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority search starting at ptr, wrapping mod N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import mux_rr_pipe_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract gives (ptr+k) mod N
      w_sum = {1'b0, ptr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(N)) begin
        w_sum = w_sum - (SW+1)'(N);
      end
      w_cand = w_sum[SW-1:0];
      if (!gnt_vld && req[w_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_pipe.sv
// ============================================================================
// Module : mux_rr_pipe
// Brief  : N:1 W-bit selector, direct or round-robin, registered valid/ready output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_rr_pipe
  import mux_rr_pipe_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] d,
  input  logic [N-1:0]   d_vld,
  output logic [N-1:0]   in_rdy,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   o,
  output logic [SW-1:0]  o_ch,
  output logic           o_vld,
  input  logic           o_rdy
);

  logic [W-1:0]  r_o;
  logic [SW-1:0] r_ch;
  logic          r_vld;
  logic [SW-1:0] r_ptr;

  logic [W-1:0]  w_ch_data [N];
  logic          w_dir_vld;
  logic          w_rr_vld;
  logic [SW-1:0] w_rr_idx;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt_idx;
  logic          w_can_load;
  logic          w_xfer;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_ch_data[i] = d[slice_lo(i, W) +: W];
  end

  // Out-of-range sel reads a zero-padded valid vector, so it can never grant.
  if (N == (1 << SW)) begin : g_sel_pow2
    assign w_dir_vld = d_vld[sel];
  end else begin : g_sel_npow2
    logic [(1<<SW)-1:0] w_vld_ext;
    assign w_vld_ext = {{((1 << SW) - N){1'b0}}, d_vld};
    assign w_dir_vld = w_vld_ext[sel];
  end

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .req     (d_vld),
    .ptr     (r_ptr),
    .gnt_vld (w_rr_vld),
    .gnt_idx (w_rr_idx)
  );

  assign w_gnt_vld  = (mode == MODE_RR) ? w_rr_vld : w_dir_vld;
  assign w_gnt_idx  = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_can_load = ~r_vld | o_rdy;
  assign w_xfer     = ~rst & w_gnt_vld & w_can_load;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_rdy[i] = w_xfer & (w_gnt_idx == SW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o   <= '0;
      r_ch  <= '0;
      r_vld <= 1'b0;
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_o   <= w_ch_data[w_gnt_idx];
      r_ch  <= w_gnt_idx;
      r_vld <= 1'b1;
      // Pointer only advances on round-robin grants; direct mode leaves it alone.
      if (mode == MODE_RR) begin
        r_ptr <= (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + SW'(1);
      end
    end else if (o_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o     = r_o;
  assign o_ch  = r_ch;
  assign o_vld = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_pipe.sv
// ============================================================================
// Module : tb_mux_rr_pipe
// Brief  : Self-checking bench for mux_rr_pipe (N=8 and N=5 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;

  logic [127:0] a_d;
  logic [7:0]   a_vld, a_in_rdy;
  logic         a_mode, a_ordy, a_ovld;
  logic [2:0]   a_sel, a_och;
  logic [15:0]  a_o;

  logic [79:0]  b_d;
  logic [4:0]   b_vld, b_in_rdy;
  logic         b_mode, b_ordy, b_ovld;
  logic [2:0]   b_sel, b_och;
  logic [15:0]  b_o;

  mux_rr_pipe #(.W(16), .N(8)) u_dut_a (
    .clk(clk), .rst(rst), .d(a_d), .d_vld(a_vld), .in_rdy(a_in_rdy),
    .mode(a_mode), .sel(a_sel), .o(a_o), .o_ch(a_och), .o_vld(a_ovld), .o_rdy(a_ordy)
  );

  mux_rr_pipe #(.W(16), .N(5)) u_dut_b (
    .clk(clk), .rst(rst), .d(b_d), .d_vld(b_vld), .in_rdy(b_in_rdy),
    .mode(b_mode), .sel(b_sel), .o(b_o), .o_ch(b_och), .o_vld(b_ovld), .o_rdy(b_ordy)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected output register contents per instance.
  int  m_o   [2];
  int  m_ch  [2];
  bit  m_ov  [2];
  int  m_ptr [2];
  bit  armed = 1'b0;

  // Channel that should be granted, or -1 for none.
  function automatic int exp_grant(input int n, input logic [7:0] vld, input bit md,
                                   input int s, input int p);
    if (!md) return (s < n && vld[s] === 1'b1) ? s : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (vld[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int id, input int n, input logic [7:0] vld, input bit md,
                            input int s, input bit ordy, input logic [127:0] dd,
                            input logic [7:0] irdy, input logic [15:0] o,
                            input logic [2:0] och, input logic ov);
    int         g;
    bit         load;
    logic [7:0] er;
    string      p;
    p = (id == 0) ? "a" : "b";
    if (armed) begin
      chk({p, "_o_vld"}, 32'(ov), 32'(m_ov[id]));
      chk({p, "_o"},     32'(o),  32'(m_o[id]));
      chk({p, "_o_ch"},  32'(och), 32'(m_ch[id]));
    end
    g    = rst ? -1 : exp_grant(n, vld, md, s, m_ptr[id]);
    load = (g >= 0) && (!m_ov[id] || ordy);
    er   = load ? (8'd1 << g) : 8'd0;
    if (armed) chk({p, "_in_rdy"}, 32'(irdy), 32'(er));
    if (rst) begin
      m_o[id] = 0; m_ch[id] = 0; m_ov[id] = 1'b0; m_ptr[id] = 0;
    end else if (load) begin
      m_o[id]  = int'(dd[g*16 +: 16]);
      m_ch[id] = g;
      m_ov[id] = 1'b1;
      if (md) m_ptr[id] = (g + 1) % n;
    end else if (ordy) begin
      m_ov[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 8, a_vld, a_mode, int'(a_sel), a_ordy, a_d, a_in_rdy, a_o, a_och, a_ovld);
    model_step(1, 5, {3'b0, b_vld}, b_mode, int'(b_sel), b_ordy, {48'b0, b_d},
               {3'b0, b_in_rdy}, b_o, b_och, b_ovld);
    if (rst) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst = 1'b1;
    a_d = '0; a_vld = 8'hFF; a_mode = 1'b1; a_sel = 3'd0; a_ordy = 1'b1;
    b_d = '0; b_vld = 5'h1F; b_mode = 1'b0; b_sel = 3'd6; b_ordy = 1'b1;
    step(); step();
    chk("rst_o", 32'(a_o), 0);
    chk("rst_o_vld", 32'(a_ovld), 0);
    chk("rst_o_ch", 32'(a_och), 0);
    chk("rst_in_rdy", 32'(a_in_rdy), 0);
    chk("rst_b_o_vld", 32'(b_ovld), 0);

    for (int i = 0; i < 8; i++) a_d[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int i = 0; i < 5; i++) b_d[i*16 +: 16] = 16'h2000 + 16'(i);
    rst = 1'b0;
    #1;
    chk("rr_first_rdy", 32'(a_in_rdy), 32'h01);
    chk("b_sel6_rdy", 32'(b_in_rdy), 0);

    // Fairness across all-valid channels, including the 7 -> 0 wrap.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rr_seq_ch", 32'(a_och), 32'(i % 8));
      chk("rr_seq_o", 32'(a_o), 32'h1000 + 32'(i % 8));
    end
    chk("b_sel6_idle", 32'(b_ovld), 0);

    a_mode = 1'b0; a_vld = 8'h20; a_sel = 3'd5; a_d[80 +: 16] = 16'hA5A5;
    #1;
    chk("dir_rdy", 32'(a_in_rdy), 32'h20);
    step();
    chk("dir_o", 32'(a_o), 32'hA5A5);
    chk("dir_o_ch", 32'(a_och), 5);
    chk("dir_o_vld", 32'(a_ovld), 1);
    a_sel = 3'd3;
    #1;
    chk("dir_novld_rdy", 32'(a_in_rdy), 0);
    step();
    chk("dir_drain_vld", 32'(a_ovld), 0);
    chk("dir_drain_o", 32'(a_o), 32'hA5A5);
    chk("dir_drain_ch", 32'(a_och), 5);

    // ptr was left at 2 by the RR run; a grant of 2 moves it to 3.
    a_mode = 1'b1; a_vld = 8'h04;
    step();
    chk("sparse_pre_ch", 32'(a_och), 2);
    a_vld = 8'h84;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2 == 0) ? 7 : 2;
      #1;
      chk("sparse_rdy", 32'(a_in_rdy), 32'(8'd1 << e));
      step();
      chk("sparse_ch", 32'(a_och), 32'(e));
    end

    a_vld = 8'hFF; a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(a_in_rdy), 0);
      step();
      chk("bp_ch", 32'(a_och), 2);
      chk("bp_o", 32'(a_o), 32'h1002);
      chk("bp_vld", 32'(a_ovld), 1);
    end
    a_ordy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(a_in_rdy), 32'h08);
    step();
    chk("bp_release_ch", 32'(a_och), 3);
    chk("bp_release_vld", 32'(a_ovld), 1);
    a_vld = 8'h00;

    // N=5: sel 6 never grants; RR wraps 4 -> 0.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("n5_sel6_rdy", 32'(b_in_rdy), 0);
      step();
      chk("n5_sel6_vld", 32'(b_ovld), 0);
    end
    b_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("n5_rr_ch", 32'(b_och), 32'(i % 5));
    end
    b_vld = 5'h00;

    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      a_d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_vld  = 8'($urandom());
      a_mode = 1'($urandom());
      a_sel  = 3'($urandom());
      a_ordy = ($urandom_range(0, 3) != 0);
      b_d    = {$urandom(), $urandom(), 16'($urandom())};
      b_vld  = 5'($urandom());
      b_mode = 1'($urandom());
      b_sel  = 3'($urandom());
      b_ordy = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_pipe.md
Name: mux_rr_pipe

Overview:
- Parametrised N-channel, W-bit operand selector with a registered output stage and valid/ready handshake on both sides.
- Two modes: direct select (external index) or round-robin scan across valid channels.
- Sits between the register file/forwarding sources and the ALU16 operand inputs, and is reused as a generic pipelined N:1 selector elsewhere in the datapath.

Parameters:
- W, 16, data width per channel.
- N, 8, channel count (2..32).
- SW, $clog2(N), select/channel-index width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- d_vld  input  N  per-channel valid.
- in_rdy  output  N  per-channel accept strobe, one-hot or zero, combinational.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SW  channel index, used in direct mode only.
- o  output  W  registered selected data.
- o_ch  output  SW  index of the channel held in o.
- o_vld  output  1  output register holds valid data.
- o_rdy  input  1  downstream accepts o this cycle.

Behaviour:
- Reset values (rst high at an edge): o=0, o_ch=0, o_vld=0, rr pointer ptr=0. in_rdy=0 while rst is high.
- Reset mid-transfer drops the held word. No in_rdy is asserted in the reset cycle.
- can_load = ~o_vld | o_rdy (single-entry output register, full throughput).
- Direct mode (mode=0):
  - grant = sel when sel < N and d_vld[sel]=1; otherwise no grant.
  - sel >= N (N not a power of 2) never grants. o holds its value. There is no Z output.
- Round-robin mode (mode=1):
  - grant = first i with d_vld[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - No valid channel means no grant.
- Transfer: when grant exists and can_load=1:
  - in_rdy[grant]=1 that cycle.
  - At the edge: o<=d[grant], o_ch<=grant, o_vld<=1.
  - In mode 1 only: ptr <= (grant==N-1) ? 0 : grant+1. The pointer wraps.
- Drain only (o_vld & o_rdy with no grant): o_vld<=0. o and o_ch keep their last values.
- Simultaneous drain and load: new word replaces old in the same edge and o_vld stays 1. No bubble.
- Back-pressure (o_vld=1, o_rdy=0): in_rdy=0, o/o_ch/ptr frozen. Channels must hold d/d_vld.
- Latency: 1 cycle from accept to o_vld. Throughput: 1 word/cycle with o_rdy held high.
- Mode switch: takes effect on the next grant. ptr is retained across direct-mode periods and is never modified in mode 0.
- in_rdy depends only on d_vld, sel, mode, ptr, o_vld, o_rdy. No combinational path from d to in_rdy.

Decomposition:
- Shared package holds:
  - MODE_DIRECT=1'b0 and MODE_RR=1'b1 constants.
  - A helper function for flattened-bus slice indexing.
- One sub-module, rr_pick (params N, SW):
  - Inputs: req[N-1:0], ptr[SW-1:0].
  - Outputs: gnt_vld, gnt_idx[SW-1:0].
  - Purely combinational rotate-priority search.
- The top level holds the output register, ptr, the mode mux and the handshake logic.

Test Plan:
- Reset: drive rst=1 for 2 cycles with d_vld all ones → o=0, o_vld=0, o_ch=0, in_rdy=0. In mode 1 after release, first grant is channel 0.
- Direct mode, N=8, W=16, o_rdy=1: d[5]=16'hA5A5, d_vld=8'h20, sel=5 → in_rdy=8'h20; next cycle o=16'hA5A5, o_ch=5, o_vld=1. Then sel=3 with d_vld[3]=0 → no in_rdy; o_vld drops to 0 after one cycle.
- Round-robin fairness: mode=1, d_vld=8'hFF, o_rdy=1 for 10 cycles → o_ch sequence 0,1,…,7,0,1. The wrap from 7 to 0 is exercised.
- Sparse RR: d_vld=8'b1000_0100, ptr=3 → grants 2? No: grant 7, then 2, then 7, alternating. Each in_rdy is one-hot.
- Back-pressure: o_vld=1, o_rdy=0 for 3 cycles with all channels valid → in_rdy=0 and o/o_ch/ptr unchanged. On o_rdy=1 the next word loads in the same edge with no bubble.
- Non-power-of-2 N=5: sel=6 in direct mode → never grants. RR over d_vld=5'b11111 wraps 4→0.
